led_flasher_bank: RTL and testbench

Parametrised multi-channel LED flasher for the silicon shell status LEDs. Each channel runs independently in OFF, ON, BLINK (programmable period and duty) or BURST (N blinks then auto-off) mode. Channels are configured at run time through a single valid/ready write port, and each output is gated by a per-channel `led_state` enable.

---
 rtl/led_flasher_pkg.sv | 21 ++
 rtl/led_flasher_channel.sv | 112 +++++++++++
 rtl/led_flasher_bank.sv | 69 ++++++
 tb/tb_led_flasher_bank.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_flasher_pkg.sv
// led_flasher_pkg
//   Shared types and constants for the LED flasher bank.
//   led_mode_t     : per-channel operating mode (OFF, ON, BLINK, BURST).
//   LED_MODE_WIDTH : bit width of a mode value on the configuration port.
//   ch_width()     : channel index width, never narrower than one bit.
package led_flasher_pkg;

  localparam int LED_MODE_WIDTH = 2;

  typedef enum logic [LED_MODE_WIDTH-1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_BURST = 2'd3
  } led_mode_t;

  function automatic int ch_width(input int num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

endpackage

// File: rtl/led_flasher_channel.sv
// led_flasher_channel
//   One LED channel: mode/period/on-time/burst registers, phase counter,
//   burst countdown and the unmasked lit indication.
// Ports:
//   clock       in   block clock
//   reset       in   synchronous, active-low reset
//   wr_en       in   write strobe for this channel (already decoded)
//   wr_mode     in   new mode (led_mode_t encoding)
//   wr_period   in   new period P; one cycle lasts P+1 clocks
//   wr_on_time  in   new lit clocks per cycle
//   wr_burst    in   new burst blink count
//   lit         out  channel wants the LED on (before led_state gating)
//   burst_done  out  one-cycle pulse after the final burst blink
module led_flasher_channel
  import led_flasher_pkg::*;
#(
  parameter int COUNT_WIDTH = 32,
  parameter int BURST_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [LED_MODE_WIDTH-1:0] wr_mode,
  input  logic [COUNT_WIDTH-1:0]    wr_period,
  input  logic [COUNT_WIDTH-1:0]    wr_on_time,
  input  logic [BURST_WIDTH-1:0]    wr_burst,
  output logic                      lit,
  output logic                      burst_done
);

  led_mode_t              mode_q, mode_d;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic [COUNT_WIDTH-1:0] on_time_q, on_time_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [BURST_WIDTH-1:0] remaining_q, remaining_d;
  logic                   done_q, done_d;
  logic                   wrap;
  logic [COUNT_WIDTH-1:0] count_inc;

  assign wrap      = (count_q == period_q);
  assign count_inc = wrap ? '0 : count_q + COUNT_WIDTH'(1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      mode_q      <= LED_OFF;
      period_q    <= '0;
      on_time_q   <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      period_q    <= period_d;
      on_time_q   <= on_time_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  // A write overrides everything else at the same edge, which is what
  // discards a coincident wrap decrement and any pending done pulse.
  always_comb begin
    mode_d      = mode_q;
    period_d    = period_q;
    on_time_d   = on_time_q;
    count_d     = '0;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    if (wr_en) begin
      mode_d      = led_mode_t'(wr_mode);
      period_d    = wr_period;
      on_time_d   = wr_on_time;
      remaining_d = wr_burst;
    end else begin
      case (mode_q)
        LED_BLINK: count_d = count_inc;
        LED_BURST: begin
          // A zero-length burst finishes at the first edge without lighting.
          if (remaining_q == '0) begin
            mode_d = LED_OFF;
            done_d = 1'b1;
          end else begin
            count_d = count_inc;
            if (wrap) begin
              remaining_d = remaining_q - BURST_WIDTH'(1);
              if (remaining_q == BURST_WIDTH'(1)) begin
                mode_d = LED_OFF;
                done_d = 1'b1;
              end
            end
          end
        end
        default: count_d = '0;
      endcase
    end
  end

  // The remaining check keeps a zero-length burst dark in its only cycle.
  always_comb begin
    lit = 1'b0;
    case (mode_q)
      LED_ON:    lit = 1'b1;
      LED_BLINK: lit = (count_q < on_time_q);
      LED_BURST: lit = (remaining_q != '0) && (count_q < on_time_q);
      default:   lit = 1'b0;
    endcase
  end

  assign burst_done = done_q;

endmodule

// File: rtl/led_flasher_bank.sv
// led_flasher_bank
//   Bank of independent LED flasher channels configured through one
//   valid/ready write port. Each LED is gated by its led_state bit.
// Ports:
//   clock        in   block clock
//   reset        in   synchronous, active-low reset
//   cfg_valid    in   configuration write request
//   cfg_ready    out  high whenever out of reset; writes never stall
//   cfg_channel  in   target channel; out-of-range indices are ignored
//   cfg_mode     in   led_mode_t value
//   cfg_period   in   period P (cycle is P+1 clocks)
//   cfg_on_time  in   lit clocks per cycle
//   cfg_burst    in   blink cycles in BURST mode
//   led_state    in   per-channel output enable (combinational gate)
//   led          out  LED drive
//   burst_done   out  per-channel one-cycle burst completion pulse
module led_flasher_bank
  import led_flasher_pkg::*;
#(
  parameter  int NUM_CHANNELS = 4,
  parameter  int COUNT_WIDTH  = 32,
  parameter  int BURST_WIDTH  = 8,
  localparam int CH_WIDTH     = ch_width(NUM_CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CH_WIDTH-1:0]       cfg_channel,
  input  logic [LED_MODE_WIDTH-1:0] cfg_mode,
  input  logic [COUNT_WIDTH-1:0]    cfg_period,
  input  logic [COUNT_WIDTH-1:0]    cfg_on_time,
  input  logic [BURST_WIDTH-1:0]    cfg_burst,
  input  logic [NUM_CHANNELS-1:0]   led_state,
  output logic [NUM_CHANNELS-1:0]   led,
  output logic [NUM_CHANNELS-1:0]   burst_done
);

  logic                    cfg_accept;
  logic [NUM_CHANNELS-1:0] lit;

  assign cfg_ready  = reset;
  assign cfg_accept = cfg_valid & reset;

  // Indices at or above NUM_CHANNELS match no strobe, so such writes vanish.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_channel
    logic wr_strobe;

    assign wr_strobe = cfg_accept && (cfg_channel == CH_WIDTH'(i));

    led_flasher_channel #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .BURST_WIDTH (BURST_WIDTH)
    ) u_channel (
      .clock      (clock),
      .reset      (reset),
      .wr_en      (wr_strobe),
      .wr_mode    (cfg_mode),
      .wr_period  (cfg_period),
      .wr_on_time (cfg_on_time),
      .wr_burst   (cfg_burst),
      .lit        (lit[i]),
      .burst_done (burst_done[i])
    );
  end

  assign led = lit & led_state;

endmodule

// File: tb/tb_led_flasher_bank.sv
// tb_led_flasher_bank
//   Directed and randomized checks of led_flasher_bank against a timeline
//   model: each channel remembers its last write and the edge it landed on,
//   and the expected LED / done values are computed arithmetically from the
//   elapsed edge count. A 3-channel copy shares the inputs and must ignore
//   channel-3 writes.
module tb_led_flasher_bank;
  import led_flasher_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int BW  = 4;

  logic           clock       = 1'b0;
  logic           reset       = 1'b0;
  logic           cfg_valid   = 1'b0;
  logic [1:0]     cfg_channel = '0;
  logic [1:0]     cfg_mode    = '0;
  logic [CW-1:0]  cfg_period  = '0;
  logic [CW-1:0]  cfg_on_time = '0;
  logic [BW-1:0]  cfg_burst   = '0;
  logic [NCH-1:0] led_state   = '0;
  logic           cfg_ready, cfg_ready3;
  logic [NCH-1:0] led, burst_done;
  logic [2:0]     led3, burst_done3;

  int    checks   = 0;
  int    failures = 0;
  int    edges    = 0;
  string tag      = "reset";

  led_mode_t m_mode [NCH];
  int        m_p    [NCH];
  int        m_on   [NCH];
  int        m_n    [NCH];
  int        m_t    [NCH];

  always #5 clock = ~clock;

  led_flasher_bank #(
    .NUM_CHANNELS (NCH),
    .COUNT_WIDTH  (CW),
    .BURST_WIDTH  (BW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_channel (cfg_channel),
    .cfg_mode    (cfg_mode),
    .cfg_period  (cfg_period),
    .cfg_on_time (cfg_on_time),
    .cfg_burst   (cfg_burst),
    .led_state   (led_state),
    .led         (led),
    .burst_done  (burst_done)
  );

  led_flasher_bank #(
    .NUM_CHANNELS (3),
    .COUNT_WIDTH  (CW),
    .BURST_WIDTH  (BW)
  ) dut3 (
    .clock       (clock),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready3),
    .cfg_channel (cfg_channel),
    .cfg_mode    (cfg_mode),
    .cfg_period  (cfg_period),
    .cfg_on_time (cfg_on_time),
    .cfg_burst   (cfg_burst),
    .led_state   (led_state[2:0]),
    .led         (led3),
    .burst_done  (burst_done3)
  );

  // e = edges since the write; cycle e shows phase e mod (P+1).
  function automatic logic model_lit(input int i);
    int e, len;
    e   = edges - m_t[i];
    len = m_p[i] + 1;
    case (m_mode[i])
      LED_ON:    return 1'b1;
      LED_BLINK: return ((e % len) < m_on[i]);
      LED_BURST: return (e < m_n[i] * len) && ((e % len) < m_on[i]);
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic model_done(input int i);
    int e, fin;
    e   = edges - m_t[i];
    fin = (m_n[i] == 0) ? 1 : m_n[i] * (m_p[i] + 1);
    return (m_mode[i] == LED_BURST) && (e == fin);
  endfunction

  task automatic check_bits(input string name, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s edge=%0d observed=%b expected=%b", tag, name, edges, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [3:0] exp_led, exp_done;
    for (int i = 0; i < NCH; i++) begin
      exp_led[i]  = model_lit(i) & led_state[i];
      exp_done[i] = model_done(i);
    end
    check_bits("led",         led,                  exp_led);
    check_bits("burst_done",  burst_done,           exp_done);
    check_bits("cfg_ready",   {3'b000, cfg_ready},  {3'b000, reset});
    check_bits("led3",        {1'b0, led3},         {1'b0, exp_led[2:0]});
    check_bits("burst_done3", {1'b0, burst_done3},  {1'b0, exp_done[2:0]});
    check_bits("cfg_ready3",  {3'b000, cfg_ready3}, {3'b000, reset});
  endtask

  // One clock edge: update the model from the inputs the DUT samples, then
  // compare on the falling edge.
  task automatic step();
    @(posedge clock);
    edges++;
    if (!reset) begin
      for (int i = 0; i < NCH; i++) m_mode[i] = LED_OFF;
    end else if (cfg_valid) begin
      m_mode[cfg_channel] = led_mode_t'(cfg_mode);
      m_p[cfg_channel]    = int'(cfg_period);
      m_on[cfg_channel]   = int'(cfg_on_time);
      m_n[cfg_channel]    = int'(cfg_burst);
      m_t[cfg_channel]    = edges;
    end
    @(negedge clock);
    checkOutput();
  endtask

  task automatic applyStimulus(input int ch, input led_mode_t mode, input int p, input int on, input int n);
    cfg_channel = 2'(ch);
    cfg_mode    = mode;
    cfg_period  = CW'(p);
    cfg_on_time = CW'(on);
    cfg_burst   = BW'(n);
    cfg_valid   = 1'b1;
    step();
    cfg_valid   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = LED_OFF;
      m_p[i] = 0; m_on[i] = 0; m_n[i] = 0; m_t[i] = 0;
    end
    $display("[TB] start");

    tag = "reset";
    reset = 1'b0;
    led_state = 4'hF;
    repeat (5) step();
    reset = 1'b1;
    step();

    tag = "blink";
    applyStimulus(1, LED_BLINK, 3, 2, 0);
    repeat (8) step();

    tag = "burst";
    applyStimulus(2, LED_BURST, 1, 1, 3);
    repeat (10) step();

    tag = "gating";
    applyStimulus(0, LED_ON, 0, 0, 0);
    led_state[0] = 1'b0; #1 checkOutput();
    led_state[0] = 1'b1; #1 checkOutput();
    led_state[0] = 1'b0; #1 checkOutput();
    led_state[0] = 1'b1; #1 checkOutput();
    applyStimulus(0, LED_OFF, 0, 0, 0);
    led_state[0] = 1'b0; #1 checkOutput();
    led_state[0] = 1'b1; #1 checkOutput();
    step();

    tag = "abort_write";
    applyStimulus(2, LED_BURST, 2, 1, 5);
    repeat (2) step();
    applyStimulus(2, LED_BLINK, 2, 1, 0);
    repeat (20) step();

    tag = "abort_reset";
    applyStimulus(2, LED_BURST, 2, 1, 5);
    repeat (2) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (20) step();

    tag = "on_zero";
    applyStimulus(0, LED_BLINK, 4, 0, 0);
    repeat (10) step();

    tag = "on_over_period";
    applyStimulus(1, LED_BLINK, 8, 9, 0);
    repeat (12) step();

    tag = "wrap_write";
    applyStimulus(2, LED_BURST, 1, 1, 2);
    repeat (3) step();
    applyStimulus(2, LED_BLINK, 2, 2, 0);
    repeat (8) step();

    tag = "burst_zero";
    applyStimulus(3, LED_BURST, 2, 2, 0);
    repeat (5) step();

    tag = "ch3_ignored_by_3ch";
    applyStimulus(0, LED_BLINK, 2, 1, 0);
    applyStimulus(1, LED_ON, 0, 0, 0);
    applyStimulus(2, LED_BURST, 1, 1, 2);
    applyStimulus(3, LED_ON, 5, 3, 7);
    applyStimulus(3, LED_BURST, 0, 1, 1);
    repeat (6) step();

    tag = "long_period";
    applyStimulus(3, LED_BLINK, 255, 128, 0);
    repeat (520) step();

    tag = "random";
    for (int k = 0; k < 400; k++) begin
      led_state = 4'($urandom);
      reset     = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 3) == 0) begin
        cfg_channel = 2'($urandom_range(0, 3));
        cfg_mode    = 2'($urandom_range(0, 3));
        cfg_period  = CW'($urandom_range(0, 6));
        cfg_on_time = CW'($urandom_range(0, 8));
        cfg_burst   = BW'($urandom_range(0, 3));
        cfg_valid   = 1'b1;
      end else begin
        cfg_valid = 1'b0;
      end
      step();
    end
    cfg_valid = 1'b0;
    reset     = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
